// File: rtl/bullet_table_pkg.sv
// Shared definitions for the bullet table and the display stage that scans it.
package bullet_table_pkg;

  localparam int unsigned X_LSB      = 23;
  localparam int unsigned Y_LSB      = 14;
  localparam int unsigned DIR_LSB    = 12;
  localparam int unsigned ACTIVE_BIT = 5;

  localparam int unsigned SPRITE_SIZE = 8;
  localparam int unsigned BULLET_SIZE = 8;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirRight = 2'd1,
    DirDown  = 2'd2,
    DirLeft  = 2'd3
  } dir_e;

  typedef enum logic {StIdle, StSweep} sweep_state_e;

  // Field order matches the bus layout: X[31:23] Y[22:14] dir[13:12] active[5].
  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    dir_e       dir;
    logic [5:0] rsvd_hi;
    logic       active;
    logic [4:0] rsvd_lo;
  } bullet_t;

  function automatic bullet_t make_bullet(logic [8:0] x, logic [8:0] y, logic [1:0] dir);
    bullet_t b;
    b        = '0;
    b.x      = x;
    b.y      = y;
    b.dir    = dir_e'(dir);
    b.active = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/bullet_table_step.sv
// Per-frame motion of one slot word: advance by SPEED or retire at the screen edge.
module bullet_step
  import bullet_table_pkg::*;
#(
  parameter int unsigned SPEED = 4,
  parameter int unsigned MAX_X = 504,
  parameter int unsigned MAX_Y = 472
) (
  input  logic [31:0] cur,
  output logic [31:0] nxt,
  output logic        retire
);

  bullet_t    b;
  bullet_t    nb;
  logic [9:0] x10;
  logic [9:0] y10;
  logic [9:0] sp;

  always_comb begin
    b      = bullet_t'(cur);
    nb     = b;
    retire = 1'b0;
    x10    = {1'b0, b.x};
    y10    = {1'b0, b.y};
    sp     = 10'(SPEED);
    if (b.active) begin
      unique case (b.dir)
        DirUp:    if (y10 < sp) retire = 1'b1;
                  else nb.y = 9'(y10 - sp);
        DirDown:  if (y10 + sp > 10'(MAX_Y)) retire = 1'b1;
                  else nb.y = 9'(y10 + sp);
        DirLeft:  if (x10 < sp) retire = 1'b1;
                  else nb.x = 9'(x10 - sp);
        DirRight: if (x10 + sp > 10'(MAX_X)) retire = 1'b1;
                  else nb.x = 9'(x10 + sp);
      endcase
    end
    if (retire) nb = '0;
    nxt = nb;
  end

endmodule

// File: rtl/bullet_table.sv
// Bullet state table: spawns on fire, sweeps one slot per cycle after each frame edge.
module bullet_table
  import bullet_table_pkg::*;
#(
  parameter int unsigned MAX_BULLETS     = 64,
  parameter int unsigned SPEED           = 4,
  parameter int unsigned MAX_X           = 504,
  parameter int unsigned MAX_Y           = 472,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_tick,
  input  logic                        fire,
  input  logic [8:0]                  fire_x,
  input  logic [8:0]                  fire_y,
  input  logic [1:0]                  fire_dir,
  output logic [32*MAX_BULLETS-1:0]   all_bullets,
  output logic                        fire_accepted,
  output logic                        fire_dropped,
  output logic [6:0]                  active_count,
  output logic                        busy
);

  localparam int unsigned IdxW = $clog2(MAX_BULLETS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(MAX_BULLETS - 1);

  sweep_state_e    state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            tick_q;
  logic [7:0]      cool_q, cool_d;
  logic [6:0]      count_q, count_d;
  logic            acc_q, drop_q;
  logic            pend_q, pend_d;
  logic [8:0]      pend_x_q, pend_y_q;
  logic [1:0]      pend_dir_q;
  logic [31:0]     slots_q [MAX_BULLETS];

  logic            tick_rise;
  logic            sweeping;
  logic            free_found;
  logic [IdxW-1:0] free_idx;
  logic            req_valid;
  logic [8:0]      req_x, req_y;
  logic [1:0]      req_dir;
  logic            accept;
  logic            drop;
  logic            capture;
  logic [31:0]     step_nxt;
  logic            step_retire;

  assign tick_rise = frame_tick & ~tick_q;
  assign sweeping  = (state_q == StSweep);

  // Lowest-index free slot wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
      if (!slots_q[i][ACTIVE_BIT]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  // A buffered fire from the last sweep takes priority over a new request.
  always_comb begin
    req_valid = pend_q | fire;
    req_x     = pend_q ? pend_x_q : fire_x;
    req_y     = pend_q ? pend_y_q : fire_y;
    req_dir   = pend_q ? pend_dir_q : fire_dir;
    accept    = !sweeping && req_valid && (cool_q == '0) && free_found &&
                (req_x <= 9'(MAX_X)) && (req_y <= 9'(MAX_Y));
    capture   = sweeping && fire && !pend_q;
    drop      = (!sweeping && ((req_valid && !accept) || (pend_q && fire))) ||
                (sweeping && fire && pend_q);
    pend_d    = pend_q;
    if (capture) pend_d = 1'b1;
    else if (!sweeping) pend_d = 1'b0;
  end

  bullet_step #(
    .SPEED (SPEED),
    .MAX_X (MAX_X),
    .MAX_Y (MAX_Y)
  ) u_step (
    .cur    (slots_q[idx_q]),
    .nxt    (step_nxt),
    .retire (step_retire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (tick_rise) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        idx_d = idx_q + IdxW'(1);
        if (idx_q == LastIdx) state_d = StIdle;
      end
    endcase
  end

  // Loading on accept wins over a coincident frame-edge decrement.
  always_comb begin
    cool_d = cool_q;
    if (accept) cool_d = 8'(COOLDOWN_FRAMES);
    else if (tick_rise && cool_q != '0) cool_d = cool_q - 8'd1;
    count_d = count_q;
    if (accept) count_d = count_q + 7'd1;
    else if (sweeping && step_retire) count_d = count_q - 7'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      tick_q     <= 1'b0;
      cool_q     <= '0;
      count_q    <= '0;
      acc_q      <= 1'b0;
      drop_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      pend_dir_q <= '0;
      for (int i = 0; i < MAX_BULLETS; i++) slots_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tick_q  <= frame_tick;
      cool_q  <= cool_d;
      count_q <= count_d;
      acc_q   <= accept;
      drop_q  <= drop;
      pend_q  <= pend_d;
      if (capture) begin
        pend_x_q   <= fire_x;
        pend_y_q   <= fire_y;
        pend_dir_q <= fire_dir;
      end
      if (accept) slots_q[free_idx] <= make_bullet(req_x, req_y, req_dir);
      else if (sweeping) slots_q[idx_q] <= step_nxt;
    end
  end

  for (genvar g = 0; g < MAX_BULLETS; g++) begin : g_bus
    assign all_bullets[32*g +: 32] = slots_q[g];
  end

  assign fire_accepted = acc_q;
  assign fire_dropped  = drop_q;
  assign active_count  = count_q;
  assign busy          = sweeping;

endmodule

// File: tb/tb_bullet_table.sv
// Randomised scoreboard bench for bullet_table against a slot-list model.
module tb_bullet_table;

  localparam int NB    = 64;
  localparam int SPD   = 4;
  localparam int MAXX  = 504;
  localparam int MAXY  = 472;
  localparam int COOL  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            frame_tick, fire;
  logic [8:0]      fire_x, fire_y;
  logic [1:0]      fire_dir;
  logic [2047:0]   all_bullets;
  logic            fire_accepted, fire_dropped, busy;
  logic [6:0]      active_count;

  logic            fire0;
  logic [8:0]      fire_x0, fire_y0;
  logic [1:0]      fire_dir0;
  logic [2047:0]   all_bullets0;
  logic            fire_accepted0, fire_dropped0, busy0;
  logic [6:0]      active_count0;
  logic            tick0;

  always #5 clk = ~clk;

  bullet_table dut (
    .clk           (clk),
    .reset         (rst_n),
    .frame_tick    (frame_tick),
    .fire          (fire),
    .fire_x        (fire_x),
    .fire_y        (fire_y),
    .fire_dir      (fire_dir),
    .all_bullets   (all_bullets),
    .fire_accepted (fire_accepted),
    .fire_dropped  (fire_dropped),
    .active_count  (active_count),
    .busy          (busy)
  );

  bullet_table #(.COOLDOWN_FRAMES(0)) dut0 (
    .clk           (clk),
    .reset         (rst_n),
    .frame_tick    (tick0),
    .fire          (fire0),
    .fire_x        (fire_x0),
    .fire_y        (fire_y0),
    .fire_dir      (fire_dir0),
    .all_bullets   (all_bullets0),
    .fire_accepted (fire_accepted0),
    .fire_dropped  (fire_dropped0),
    .active_count  (active_count0),
    .busy          (busy0)
  );

  int total = 0;
  int bad   = 0;
  int busy_cnt = 0;

  // Reference model: plain per-slot positions.
  int  mx [NB];
  int  my [NB];
  int  md [NB];
  bit  mact [NB];
  int  mcool = 0;
  bit  mpend = 0;
  int  px, py, pd;

  typedef struct {bit acc; int cnt;} exp_t;
  exp_t expq [$];

  function automatic logic [31:0] word(int x, int y, int d);
    logic [31:0] w;
    logic [8:0]  xs, ys;
    logic [1:0]  ds;
    xs = 9'(x); ys = 9'(y); ds = 2'(d);
    w = '0;
    w[31:23] = xs;
    w[22:14] = ys;
    w[13:12] = ds;
    w[5] = 1'b1;
    return w;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NB; i++) if (mact[i]) c++;
    return c;
  endfunction

  function automatic logic [2047:0] model_bus();
    logic [2047:0] b = '0;
    for (int i = 0; i < NB; i++) if (mact[i]) b[32*i +: 32] = word(mx[i], my[i], md[i]);
    return b;
  endfunction

  task automatic model_service(input int x, input int y, input int d);
    int slot = -1;
    exp_t e;
    for (int i = NB - 1; i >= 0; i--) if (!mact[i]) slot = i;
    if (mcool == 0 && slot >= 0 && x <= MAXX && y <= MAXY) begin
      mact[slot] = 1; mx[slot] = x; my[slot] = y; md[slot] = d;
      mcool = COOL;
      e.acc = 1;
    end else begin
      e.acc = 0;
    end
    e.cnt = model_count();
    expq.push_back(e);
  endtask

  task automatic model_sweep();
    for (int i = 0; i < NB; i++) begin
      if (mact[i]) begin
        case (md[i])
          0: if (my[i] < SPD) mact[i] = 0; else my[i] -= SPD;
          1: if (mx[i] + SPD > MAXX) mact[i] = 0; else mx[i] += SPD;
          2: if (my[i] + SPD > MAXY) mact[i] = 0; else my[i] += SPD;
          default: if (mx[i] < SPD) mact[i] = 0; else mx[i] -= SPD;
        endcase
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic chk_bus(input string name, input logic [2047:0] got, input logic [2047:0] want);
    total++;
    if (got !== want) begin
      bad++;
      for (int i = 0; i < NB; i++) begin
        if (got[32*i +: 32] !== want[32*i +: 32]) begin
          $display("FAIL %s slot %0d got=%h want=%h", name, i, got[32*i +: 32],
                   want[32*i +: 32]);
          break;
        end
      end
    end
  endtask

  // Monitor: every accept/drop pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) busy_cnt++;
    if (fire_accepted === 1'b1 || fire_dropped === 1'b1) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse acc=%0b drop=%0b", fire_accepted, fire_dropped);
      end else begin
        e = expq.pop_front();
        if (fire_accepted !== e.acc || fire_dropped !== !e.acc ||
            (e.cnt >= 0 && active_count !== 7'(e.cnt))) begin
          bad++;
          $display("FAIL fire_outcome got acc=%0b drop=%0b cnt=%0d want acc=%0b cnt=%0d",
                   fire_accepted, fire_dropped, active_count, e.acc, e.cnt);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fire_idle(input int x, input int y, input int d);
    fire = 1; fire_x = 9'(x); fire_y = 9'(y); fire_dir = 2'(d);
    model_service(x, y, d);
    step(1);
    fire = 0;
  endtask

  task automatic fire_mid(input int x, input int y, input int d);
    exp_t e;
    fire = 1; fire_x = 9'(x); fire_y = 9'(y); fire_dir = 2'(d);
    if (!mpend) begin
      mpend = 1; px = x; py = y; pd = d;
    end else begin
      e.acc = 0; e.cnt = -1;
      expq.push_back(e);
    end
    step(1);
    fire = 0;
  endtask

  function automatic int rnd_x();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(505, 511))
                                       : int'($urandom_range(0, MAXX));
  endfunction

  function automatic int rnd_y();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(473, 511))
                                       : int'($urandom_range(0, MAXY));
  endfunction

  task automatic do_frame(input int nmid);
    int guard;
    busy_cnt = 0;
    frame_tick = 1;
    mcool = (mcool > 0) ? mcool - 1 : 0;
    step(1);
    frame_tick = 0;
    for (int k = 0; k < nmid; k++) begin
      step($urandom_range(0, 29));
      fire_mid(rnd_x(), rnd_y(), $urandom_range(0, 3));
    end
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (busy !== 1'b0 && guard < 100);
    if (guard >= 100) chk("sweep_timeout", 64'(busy), 64'd0);
    model_sweep();
    if (mpend) begin
      mpend = 0;
      model_service(px, py, pd);
    end
    step(2);
    chk("busy_len", 64'(busy_cnt), 64'd64);
    chk("active_count", 64'(active_count), 64'(model_count()));
    chk_bus("bus_frame", all_bullets, model_bus());
  endtask

  task automatic cool_wait();
    while (mcool > 0) do_frame(0);
  endtask

  logic [2047:0] exp0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; frame_tick = 0; fire = 0; fire_x = 0; fire_y = 0; fire_dir = 0;
    tick0 = 0; fire0 = 0; fire_x0 = 0; fire_y0 = 0; fire_dir0 = 0;
    for (int i = 0; i < NB; i++) begin mact[i] = 0; mx[i] = 0; my[i] = 0; md[i] = 0; end
    step(3);
    @(negedge clk);
    chk_bus("reset_bus", all_bullets, '0);
    chk("reset_count", 64'(active_count), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_acc", 64'(fire_accepted), 64'd0);
    chk("reset_drop", 64'(fire_dropped), 64'd0);
    @(posedge clk); #1 rst_n = 1;
    step(2);

    // First shot lands in slot 0, then moves right by one step.
    fire_idle(100, 200, 1);
    step(2);
    chk("slot0_word", 64'(all_bullets[31:0]), 64'(word(100, 200, 1)));
    chk("count_one", 64'(active_count), 64'd1);
    do_frame(0);
    chk("slot0_moved", 64'(all_bullets[31:0]), 64'(word(104, 200, 1)));

    // Cooldown: retry after 3 frames is dropped, after 8 more accepted.
    cool_wait();
    fire_idle(50, 60, 2);
    step(1);
    repeat (3) do_frame(0);
    fire_idle(70, 80, 2);
    step(1);
    repeat (8) do_frame(0);
    fire_idle(90, 90, 3);
    step(2);

    // Screen-edge boundaries.
    cool_wait(); fire_idle(300, 2, 0);   step(1); do_frame(0);
    cool_wait(); fire_idle(300, 4, 0);   step(1); do_frame(0);
    cool_wait(); fire_idle(504, 100, 1); step(1); do_frame(0);
    cool_wait(); fire_idle(500, 120, 1); step(1); do_frame(0);
    cool_wait(); fire_idle(3, 140, 3);   step(1); do_frame(0);
    cool_wait(); fire_idle(10, 470, 2);  step(1); do_frame(0);
    cool_wait(); fire_idle(505, 10, 1);  step(1);
    cool_wait(); fire_idle(10, 473, 1);  step(1);

    // Two fires mid-sweep: first buffered and accepted, second dropped.
    cool_wait();
    do_frame(2);

    // Random traffic.
    for (int f = 0; f < 120; f++) begin
      int n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        fire_idle(rnd_x(), rnd_y(), $urandom_range(0, 3));
        step($urandom_range(0, 2));
      end
      do_frame($urandom_range(0, 2));
    end
    step(3);
    chk("queue_drained", 64'(expq.size()), 64'd0);

    // Fill every slot on the zero-cooldown build, then one more is dropped.
    exp0 = '0;
    for (int i = 0; i < NB; i++) begin
      fire0 = 1; fire_x0 = 9'(i * 7); fire_y0 = 9'(i); fire_dir0 = 2'(i % 4);
      exp0[32*i +: 32] = word(i * 7, i, i % 4);
      @(posedge clk); #1 fire0 = 0;
      @(negedge clk);
      chk("fill_acc", 64'(fire_accepted0), 64'd1);
      @(posedge clk); #1;
    end
    fire0 = 1; fire_x0 = 9'd5; fire_y0 = 9'd5; fire_dir0 = 2'd0;
    @(posedge clk); #1 fire0 = 0;
    @(negedge clk);
    chk("full_drop", 64'(fire_dropped0), 64'd1);
    chk("full_noacc", 64'(fire_accepted0), 64'd0);
    chk("full_count", 64'(active_count0), 64'd64);
    chk_bus("full_bus", all_bullets0, exp0);

    // Reset mid-sweep aborts at once.
    @(posedge clk); #1 frame_tick = 1;
    step(1);
    frame_tick = 0;
    step(10);
    rst_n = 0;
    #2;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_count", 64'(active_count), 64'd0);
    chk_bus("midreset_bus", all_bullets, '0);
    chk("midreset_count0", 64'(active_count0), 64'd0);
    step(2);
    rst_n = 1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
